// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath constants and upsampler state type
package cnn_pkg;

    localparam int DATA_WIDTH   = 20;
    localparam int CONV_OUT_DIM = 26;
    localparam int POOL_OUT_DIM = 13;

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } up_state_e;

endpackage

// File: rtl/upsample_2x_if.sv
// rtl/upsample_2x_if.sv - input/output pixel stream bundle for the 2x upsampler
interface upsample_2x_if #(
    parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH
);
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         valid_in;
    logic                         ready_in;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic                         valid_out;
    logic                         ready_out;
    logic                         frame_done;
    logic                         busy;

    modport slave (
        input  data_in, valid_in, ready_out,
        output ready_in, data_out, valid_out, frame_done, busy
    );

    modport master (
        output data_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out, frame_done, busy
    );
endinterface

// File: rtl/upsample_2x_line_buf.sv
// rtl/upsample_2x_line_buf.sv - one-row simple dual-port line buffer, async read
module line_buf_sdp #(
    parameter int DEPTH  = 13,
    parameter int WIDTH  = 20,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/upsample_2x.sv
// rtl/upsample_2x.sv - streaming 2x nearest-neighbour upsampler (each pixel -> 2x2 block)
module upsample_2x #(
    parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int IN_WIDTH   = cnn_pkg::POOL_OUT_DIM,
    parameter int IN_HEIGHT  = cnn_pkg::POOL_OUT_DIM
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    upsample_2x_if.slave   bus
);
    import cnn_pkg::*;

    localparam int CW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

    up_state_e                    state_q;
    logic [CW-1:0]                col_q;
    logic [RW-1:0]                row_q;
    logic                         dup_q;
    logic                         valid_q;
    logic                         busy_q;
    logic signed [DATA_WIDTH-1:0] data_q;

    logic                  out_xfer;
    logic                  in_xfer;
    logic                  pair_done;
    logic                  col_last;
    logic                  row_last;
    logic [CW-1:0]         col_inc;
    logic [CW-1:0]         lb_waddr;
    logic [CW-1:0]         lb_raddr;
    logic [DATA_WIDTH-1:0] lb_rdata;

    assign col_inc   = col_q + 1'b1;
    assign col_last  = (col_q == COL_LAST);
    assign row_last  = (row_q == ROW_LAST);
    assign out_xfer  = valid_q & bus.ready_out & enable;
    assign pair_done = out_xfer & dup_q;

    // A new pixel may land in the hold register in the same cycle the second copy
    // leaves, except at the row end where the block switches to replaying the row.
    assign bus.ready_in = enable & (state_q == FILL)
                        & (~valid_q | (pair_done & ~col_last));
    assign in_xfer      = bus.valid_in & bus.ready_in;

    assign lb_waddr = valid_q ? col_inc : col_q;
    assign lb_raddr = (state_q == REPLAY) ? col_inc : '0;

    assign bus.valid_out  = valid_q & enable;
    assign bus.data_out   = data_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = pair_done & (state_q == REPLAY) & col_last & row_last;

    line_buf_sdp #(
        .DEPTH  (IN_WIDTH),
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (CW)
    ) u_line_buf (
        .clk   (clk),
        .we    (in_xfer),
        .waddr (lb_waddr),
        .wdata (bus.data_in),
        .raddr (lb_raddr),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            dup_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else if (enable) begin
            case (state_q)
                FILL: begin
                    if (pair_done) begin
                        dup_q <= 1'b0;
                        if (col_last) begin
                            col_q   <= '0;
                            state_q <= REPLAY;
                            data_q  <= lb_rdata;
                        end else begin
                            col_q   <= col_inc;
                            valid_q <= 1'b0;
                        end
                    end else if (out_xfer) begin
                        dup_q <= 1'b1;
                    end
                    if (in_xfer) begin
                        data_q  <= bus.data_in;
                        valid_q <= 1'b1;
                        dup_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                REPLAY: begin
                    if (pair_done) begin
                        dup_q <= 1'b0;
                        if (col_last) begin
                            col_q   <= '0;
                            valid_q <= 1'b0;
                            state_q <= FILL;
                            if (row_last) begin
                                row_q  <= '0;
                                busy_q <= 1'b0;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q  <= col_inc;
                            data_q <= lb_rdata;
                        end
                    end else if (out_xfer) begin
                        dup_q <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
